bullet_fire_ctrl: RTL and testbench
===================================

Name: bullet_fire_ctrl

Overview:
- Upstream/downstream partner of the bullet Y counter; owns the bullet lifecycle.
- Turns the player's fire button into the counter's enable, latches bullet X at launch, reads the counter's Y back, and ends flight on a target hit or on reaching the screen top.
- Produces the hit pulse, saturating score and visibility flag consumed by the VGA renderer.

Parameters:
START_Y, 400, Y value the counter holds while disabled; launch row.
TOP_Y, 8, flight ends when bullet_y <= TOP_Y.
TARGET_W, 32, target hitbox width in pixels.
TARGET_H, 16, target hitbox height in pixels.
COOLDOWN_CYC, 64, clk cycles spent in COOLDOWN before re-arming.

Ports:
clk  in  1  system clock; same clock that drives the bullet Y counter.
reset  in  1  asynchronous, active-low.
fire_btn  in  1  raw fire button, asynchronous to clk.
player_x  in  10  current player X; sampled at launch.
bullet_y  in  10  Y position returned by the bullet counter.
target_x  in  10  target hitbox left edge.
target_y  in  10  target hitbox top edge.
target_alive  in  1  target is currently collidable.
bullet_enb  out  1  enable to the bullet counter; low forces the counter to START_Y.
bullet_x  out  10  latched bullet X.
bullet_visible  out  1  high only in FLIGHT.
hit_pulse  out  1  one-cycle pulse on a hit.
score  out  8  hit count, saturates at 255.

Behaviour:
- Reset is asynchronous, active-low, on clk.
- Reset values: state=IDLE, bullet_enb=0, bullet_x=0, bullet_visible=0, hit_pulse=0, score=0, synchroniser flops=0, cooldown count=0.
- Fire input path: fire_btn passes through a 2-flop synchroniser, then rising-edge detect (sync2 & ~sync3). fire_rise is valid 3 clk cycles after the button edge.
- FSM (registered state) has four states: IDLE, FLIGHT, HIT, COOLDOWN.
- IDLE:
  - bullet_enb=0.
  - On fire_rise: go to FLIGHT, bullet_x<=player_x, bullet_enb<=1 on the same edge.
- FLIGHT:
  - bullet_enb=1, bullet_visible=1.
  - Hit condition, evaluated every cycle: target_alive && target_x <= bullet_x < target_x+TARGET_W && target_y <= bullet_y < target_y+TARGET_H. Sums are computed in 11 bits so there is no wrap at the right or bottom edge.
  - If hit, go to HIT.
  - Else if bullet_y <= TOP_Y or bullet_y > START_Y (underflow guard), go to COOLDOWN.
  - Hit takes priority when both conditions are true in the same cycle.
  - fire_rise is ignored; presses are not queued.
- HIT:
  - Lasts exactly one cycle; bullet_enb=0, hit_pulse=1.
  - score<=score+1 unless score is already 255.
  - Next state is COOLDOWN.
- COOLDOWN:
  - bullet_enb=0.
  - Counter loads 0 on entry and increments each cycle.
  - Leaves to IDLE when count==COOLDOWN_CYC-1, i.e. COOLDOWN_CYC cycles spent in COOLDOWN.
  - fire_rise is ignored.
- Latency:
  - fire_rise edge to bullet_enb high: 1 clk.
  - Hit detect cycle to hit_pulse: 1 clk.
  - bullet_enb falls on the same edge that enters HIT or COOLDOWN.
- Outputs bullet_enb, bullet_visible and hit_pulse are all registered; no combinational path from the inputs.
- bullet_x holds its value after flight ends, until the next launch.
- Reset asserted mid-flight: immediate return to IDLE with bullet_enb=0, which also forces the counter back to START_Y.
- target_alive dropping mid-flight: no hit is possible; the bullet continues to TOP_Y.
- score persists through flights and cooldowns; only reset clears it.

Decomposition:
- Shared game package holds: the state encoding (2-bit IDLE=0, FLIGHT=1, HIT=2, COOLDOWN=3), START_Y, SCREEN_W=640, SCREEN_H=480, and the target size constants. The bullet counter also uses START_Y from this package.
- One natural sub-module, btn_sync_edge: a 2-flop synchroniser plus rising-edge detector, reusable for the other buttons.
- Hitbox compare stays inline.

Test Plan:
- Reset then fire press with player_x=100 → bullet_enb=1 four cycles after the press, bullet_x=100, bullet_visible=1.
- Bench models the counter (bullet_y falls by 1 per clk from 400), target_alive=0 → exit to COOLDOWN when bullet_y=8; bullet_enb=0 on that edge; IDLE after 64 further cycles; score stays 0.
- target_x=90, target_y=200, target_alive=1, bullet_x=100 → hit_pulse high for exactly 1 cycle after bullet_y=215; score=1; bullet_enb=0.
- Edge cases, each checked separately:
  - bullet_x=122 (=target_x+TARGET_W) → no hit.
  - target_x=1000 (sum 1032 > 1023, exercises 11-bit compare) → no false hit.
  - bullet_y=8 inside the hitbox → HIT wins.
- Fire presses during FLIGHT and COOLDOWN → ignored; bullet_x unchanged; no relaunch until IDLE plus a new press.
- Preload 255 hits → score stays 255 on a further hit. Reset pulse mid-FLIGHT → IDLE, all outputs at reset values, score=0.

Source files
------------

// File: rtl/bullet_fire_ctrl_pkg.sv
// rtl/bullet_fire_ctrl_pkg.sv - shared game constants and bullet FSM encoding
package bullet_fire_ctrl_pkg;

    typedef logic [9:0] coord_t;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLIGHT   = 2'd1;
    localparam logic [1:0] ST_HIT      = 2'd2;
    localparam logic [1:0] ST_COOLDOWN = 2'd3;

    // The bullet Y counter parks at GAME_START_Y whenever its enable is low.
    localparam int GAME_START_Y  = 400;
    localparam int GAME_SCREEN_W = 640;
    localparam int GAME_SCREEN_H = 480;
    localparam int GAME_TARGET_W = 32;
    localparam int GAME_TARGET_H = 16;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bullet_fire_ctrl_btn_sync_edge.sv
// rtl/bullet_fire_ctrl_btn_sync_edge.sv - two-flop button synchroniser with registered rising-edge pulse
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    // sync1/sync2 resolve metastability; sync3 is the previous clean level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            sync3 <= sync2;
            rise  <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/bullet_fire_ctrl.sv
// rtl/bullet_fire_ctrl.sv - bullet lifecycle FSM: launch, flight, hit scoring and cooldown
module bullet_fire_ctrl
    import bullet_fire_ctrl_pkg::*;
#(
    parameter int START_Y      = GAME_START_Y,
    parameter int TOP_Y        = 8,
    parameter int TARGET_W     = GAME_TARGET_W,
    parameter int TARGET_H     = GAME_TARGET_H,
    parameter int COOLDOWN_CYC = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire_btn,
    input  logic [9:0] player_x,
    input  logic [9:0] bullet_y,
    input  logic [9:0] target_x,
    input  logic [9:0] target_y,
    input  logic       target_alive,
    output logic       bullet_enb,
    output logic [9:0] bullet_x,
    output logic       bullet_visible,
    output logic       hit_pulse,
    output logic [7:0] score
);

    localparam int              CD_W      = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
    localparam logic [CD_W-1:0] CD_LAST   = CD_W'(COOLDOWN_CYC - 1);
    localparam logic [9:0]      TOP_Y_C   = 10'(TOP_Y);
    localparam logic [9:0]      START_Y_C = 10'(START_Y);
    localparam logic [10:0]     TW        = 11'(TARGET_W);
    localparam logic [10:0]     TH        = 11'(TARGET_H);

    logic [1:0]      state;
    logic [CD_W-1:0] cd_cnt;
    logic            fire_rise;
    logic [10:0]     x_end;
    logic [10:0]     y_end;
    logic            in_x;
    logic            in_y;
    logic            hit;
    logic            flight_done;

    btn_sync_edge u_fire_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (fire_btn),
        .rise  (fire_rise)
    );

    // Right/bottom hitbox edges in 11 bits so a target near 1023 cannot wrap.
    always_comb begin
        x_end       = {1'b0, target_x} + TW;
        y_end       = {1'b0, target_y} + TH;
        in_x        = (bullet_x >= target_x) && ({1'b0, bullet_x} < x_end);
        in_y        = (bullet_y >= target_y) && ({1'b0, bullet_y} < y_end);
        hit         = target_alive && in_x && in_y;
        flight_done = (bullet_y <= TOP_Y_C) || (bullet_y > START_Y_C);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            cd_cnt         <= '0;
            bullet_enb     <= 1'b0;
            bullet_x       <= 10'd0;
            bullet_visible <= 1'b0;
            hit_pulse      <= 1'b0;
            score          <= 8'd0;
        end else begin
            hit_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fire_rise) begin
                        state          <= ST_FLIGHT;
                        bullet_x       <= player_x;
                        bullet_enb     <= 1'b1;
                        bullet_visible <= 1'b1;
                    end
                end
                ST_FLIGHT: begin
                    // A hit on the last row still counts: hit outranks flight_done.
                    if (hit) begin
                        state          <= ST_HIT;
                        bullet_enb     <= 1'b0;
                        bullet_visible <= 1'b0;
                        hit_pulse      <= 1'b1;
                    end else if (flight_done) begin
                        state          <= ST_COOLDOWN;
                        cd_cnt         <= '0;
                        bullet_enb     <= 1'b0;
                        bullet_visible <= 1'b0;
                    end
                end
                ST_HIT: begin
                    state  <= ST_COOLDOWN;
                    cd_cnt <= '0;
                    score  <= sat_inc8(score);
                end
                default: begin
                    if (cd_cnt == CD_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cd_cnt <= cd_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// tb/tb_bullet_fire_ctrl.sv - scoreboard bench for bullet_fire_ctrl with a bullet Y counter model
module tb_bullet_fire_ctrl;

    localparam int EV_LAUNCH = 0;
    localparam int EV_HIT    = 1;
    localparam int EV_TOP    = 2;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       fire_btn = 1'b0;
    logic [9:0] player_x = 10'd0;
    logic [9:0] bullet_y = 10'd400;
    logic [9:0] target_x = 10'd0;
    logic [9:0] target_y = 10'd0;
    logic       target_alive = 1'b0;
    logic       bullet_enb;
    logic [9:0] bullet_x;
    logic       bullet_visible;
    logic       hit_pulse;
    logic [7:0] score;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  exp_score = 0;
    ev_t exp_q[$];
    bit  prev_enb = 1'b0;
    bit  pend = 1'b0;
    int  pend_val = 0;

    // px, tx, ty, alive_from(-1 never, 0 always, n from L+n), end offset, is_hit, noise presses
    int vec [8][7] = '{
        '{100,    0,   0,  -1, 393, 0, 1},
        '{100,   90, 200,   0, 186, 1, 0},
        '{122,   90, 200,   0, 393, 0, 0},
        '{5,   1000, 200,   0, 393, 0, 0},
        '{1010, 1000, 200,  0, 186, 1, 0},
        '{100,   90,   0, 392, 393, 1, 0},
        '{121,   90, 200,   0, 186, 1, 0},
        '{90,    90, 385,   0,   1, 1, 0}
    };

    bullet_fire_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .fire_btn       (fire_btn),
        .player_x       (player_x),
        .bullet_y       (bullet_y),
        .target_x       (target_x),
        .target_y       (target_y),
        .target_alive   (target_alive),
        .bullet_enb     (bullet_enb),
        .bullet_x       (bullet_x),
        .bullet_visible (bullet_visible),
        .hit_pulse      (hit_pulse),
        .score          (score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bullet Y counter: parks at 400 while disabled, falls one row per clock when enabled.
    always @(posedge clk) bullet_y <= bullet_enb ? bullet_y - 10'd1 : 10'd400;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial begin : monitor
        ev_t e;
        int  kind;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_enb = 1'b0;
                pend     = 1'b0;
            end else begin
                check("visible_eq_enb", 32'(bullet_visible), 32'(bullet_enb));
                if (pend) begin
                    check("score_after_hit", 32'(score), 32'(pend_val));
                    pend = 1'b0;
                end
                kind = -1;
                if (hit_pulse)                    kind = EV_HIT;
                else if (bullet_enb && !prev_enb) kind = EV_LAUNCH;
                else if (!bullet_enb && prev_enb) kind = EV_TOP;
                if (kind >= 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", 32'(kind), 32'(e.kind));
                        check("event_cycle", 32'(cyc), 32'(e.cyc));
                        if (kind == EV_LAUNCH) check("launch_bullet_x", 32'(bullet_x), 32'(e.val));
                        if (kind == EV_HIT) begin
                            check("hit_enb_low", 32'(bullet_enb), 32'd0);
                            pend     = 1'b1;
                            pend_val = e.val;
                        end
                    end
                end
                prev_enb = bullet_enb;
            end
        end
    end

    task automatic at_cycle(input int t);
        while (cyc < t) @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enb"}, 32'(bullet_enb), 32'd0);
        check({tag, "_visible"}, 32'(bullet_visible), 32'd0);
        check({tag, "_hit"}, 32'(hit_pulse), 32'd0);
        check({tag, "_bullet_x"}, 32'(bullet_x), 32'd0);
        check({tag, "_score"}, 32'(score), 32'd0);
    endtask

    task automatic run_flight(input int px, input int tx, input int ty, input int alive_from,
                              input int end_off, input int is_hit, input int noise);
        int  l;
        int  e_cyc;
        ev_t e;
        target_x     = 10'(tx);
        target_y     = 10'(ty);
        target_alive = (alive_from == 0);
        @(negedge clk);
        #1;
        player_x = 10'(px);
        fire_btn = 1'b1;
        l        = cyc + 4;
        e_cyc    = l + end_off;
        e.kind = EV_LAUNCH; e.cyc = l; e.val = px;
        exp_q.push_back(e);
        if (is_hit != 0) begin
            exp_score = (exp_score == 255) ? 255 : exp_score + 1;
            e.kind = EV_HIT; e.cyc = e_cyc; e.val = exp_score;
        end else begin
            e.kind = EV_TOP; e.cyc = e_cyc; e.val = 0;
        end
        exp_q.push_back(e);
        at_cycle(l + 2);
        fire_btn = 1'b0;
        if (alive_from > 0) begin
            at_cycle(l + alive_from);
            target_alive = 1'b1;
        end
        if (noise != 0) begin
            at_cycle(l + 50);
            player_x = 10'd300;
            fire_btn = 1'b1;
            at_cycle(l + 56);
            fire_btn = 1'b0;
            at_cycle(e_cyc + 6);
            fire_btn = 1'b1;
            at_cycle(e_cyc + 10);
            fire_btn = 1'b0;
            // Rise reaches the FSM on the very edge that leaves COOLDOWN; held into IDLE.
            at_cycle(e_cyc + 60);
            fire_btn = 1'b1;
            at_cycle(e_cyc + 70);
            fire_btn = 1'b0;
        end
        at_cycle(e_cyc + 72);
        check("bullet_x_hold", 32'(bullet_x), 32'(px));
        check("score_steady", 32'(score), 32'(exp_score));
        target_alive = 1'b0;
    endtask

    initial begin : stimulus
        int  l;
        ev_t e;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_flight(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4], vec[i][5], vec[i][6]);
        end

        for (int i = 0; i < 251; i++) begin
            run_flight(90, 90, 385, 0, 1, 1, 0);
        end
        check("score_saturated", 32'(score), 32'd255);

        @(negedge clk);
        #1;
        player_x = 10'd200;
        fire_btn = 1'b1;
        l        = cyc + 4;
        e.kind = EV_LAUNCH; e.cyc = l; e.val = 200;
        exp_q.push_back(e);
        at_cycle(l + 50);
        check("midflight_enb", 32'(bullet_enb), 32'd1);
        fire_btn = 1'b0;
        reset    = 1'b0;
        #1;
        check_reset_outputs("midflight_reset");
        exp_score = 0;
        at_cycle(l + 53);
        reset = 1'b1;

        run_flight(100, 90, 200, 0, 186, 1, 0);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
